seg_scan_arbiter: RTL and testbench
===================================

SEG_SCAN_ARBITER -- requirements
Module: seg_scan_arbiter

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 13: scan tick every 2^SCAN_DIV clk cycles.
REQ-002 SHALL have parameter HOLD_FRAMES, default 4: minimum frames an owner keeps the display while the other side requests; range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state on posedge clk.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_a  input  1  requester A wants the display.
REQ-006 SHALL have port data_a  input  16  A's four BCD/hex nibbles; [3:0] is the rightmost digit.
REQ-007 SHALL have port req_b  input  1  requester B wants the display.
REQ-008 SHALL have port data_b  input  16  B's nibbles, same layout as data_a.
REQ-009 SHALL have port gnt_a  output  1  A owns the display (registered).
REQ-010 SHALL have port gnt_b  output  1  B owns the display (registered).
REQ-011 SHALL have port DIGIT  output  4  active-low digit enable, one-hot-low.
REQ-012 SHALL have port DISPLAY  output  7 ([0:6])  active-low segments a..g.

Function
REQ-013 SHALL run a SCAN_DIV-bit free-running prescaler; tick = one-cycle pulse when prescaler is all ones.
REQ-014 SHALL advance a 2-bit digit pointer 0->1->2->3->0 on each tick; frame boundary = tick with pointer==3.
REQ-015 SHALL implement FSM IDLE, OWN_A, OWN_B; transitions only at frame boundaries.
REQ-016 IDLE: grant the sole requester; if both request, grant the side not in last_owner (round robin).
REQ-017 OWN_x: if req_x low at boundary -> grant the other side if requesting, else IDLE.
REQ-018 OWN_x with req_x high and the other side requesting: switch when hold count >= HOLD_FRAMES, else stay.
REQ-019 Hold count SHALL clear on each grant change, increment per frame boundary, saturate at HOLD_FRAMES.
REQ-020 gnt_a/gnt_b SHALL equal (state==OWN_A)/(state==OWN_B); never both high.
REQ-021 At each boundary the new owner's data SHALL latch into a 16-bit frame register; input changes mid-frame are invisible until the next boundary (no tearing).
REQ-022 In OWN states DIGIT SHALL be 1110/1101/1011/0111 for pointer 0/1/2/3, showing frame nibble [3:0]/[7:4]/[11:8]/[15:12].
REQ-023 In IDLE DIGIT SHALL be 1111 and DISPLAY 1111111.
REQ-024 Decode, active-low a..g: 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111 8=0000000 9=0000100.
REQ-025 DIGIT/DISPLAY SHALL be combinational from registered state/pointer/frame only; no input-to-output paths.

Reset
REQ-026 On reset low, immediately and asynchronously: state IDLE, gnt_a=gnt_b=0, prescaler 0, pointer 0, hold 0, frame 16'h0000, last_owner=B (A wins first tie), DIGIT=1111, DISPLAY=1111111.
REQ-027 Reset mid-frame SHALL abort the frame; after release the first grant occurs at the next frame boundary.

Configuration
REQ-028 Macro SEG_SCAN_HEX_EN defined: nibbles 10..15 SHALL decode A=0001000 b=1100000 C=0110001 d=1000010 E=0110000 F=0111000.
REQ-029 Macro SEG_SCAN_HEX_EN undefined: nibbles 10..15 SHALL decode as dash 1111110.

Verification (SCAN_DIV=2, HOLD_FRAMES=2: tick every 4 clk, frame 16 clk)
REQ-030 Reset low mid-scan -> same cycle DIGIT=1111, DISPLAY=1111111, gnt_a=gnt_b=0.
REQ-031 req_a=1, data_a=16'h1234 -> gnt_a high within 16 clk; DIGIT=1110 with DISPLAY=1001100, then 1101/0000110, 1011/0010010, 0111/1001111.
REQ-032 req_a=req_b=1 from IDLE -> A granted first; ownership alternates A,B,A every 2 frames; gnt never both high.
REQ-033 data_a 16'h1234->16'h5678 at pointer 1 -> digits stay 1234 to frame end, 5678 from next frame.
REQ-034 OWN_A, req_a drops mid-frame -> gnt_a holds to boundary, then IDLE (or OWN_B if req_b=1) regardless of hold count.
REQ-035 data_a=16'h00AF -> digit 0: 0111000 with SEG_SCAN_HEX_EN, 1111110 without; digit 1: 0001000 / 1111110.

Source files
------------

// File: rtl/seg_scan_arbiter.sv
// seg_scan_arbiter: two requesters share one multiplexed 4-digit 7-segment
// display. Ownership changes only at frame boundaries, and a frame register
// snapshots the owner's data there, so a frame never shows mixed data.
// An owner keeps the display for at least HOLD_FRAMES complete frames while
// the other side is waiting.
// Optional feature: define SEG_SCAN_HEX_EN to decode nibbles 10..15 as A-F;
// without it those nibbles show a dash.
module seg_scan_arbiter #(
    parameter int unsigned SCAN_DIV    = 13,
    parameter int unsigned HOLD_FRAMES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_a,
    input  logic [15:0] data_a,
    input  logic        req_b,
    input  logic [15:0] data_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic [3:0]  DIGIT,
    output logic [0:6]  DISPLAY
);

    localparam int unsigned HOLD_W = 4;
    localparam int unsigned CMP_W  = HOLD_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [SCAN_DIV-1:0] prescaler;
    logic [1:0]          ptr;
    logic [HOLD_W-1:0]   hold;
    logic [15:0]         frame;
    logic                last_owner;   // 0: A owned last, 1: B owned last
    logic                tick;
    logic                boundary;
    logic                hold_met;
    logic [3:0]          nibble;

    // Active-low a..g pattern for one nibble; DISPLAY[0] is segment a.
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
`ifdef SEG_SCAN_HEX_EN
            4'd10:   s = 7'b0001000;
            4'd11:   s = 7'b1100000;
            4'd12:   s = 7'b0110001;
            4'd13:   s = 7'b1000010;
            4'd14:   s = 7'b0110000;
            default: s = 7'b0111000;
`else
            default: s = 7'b1111110;
`endif
        endcase
        return s;
    endfunction

    assign tick     = &prescaler;
    assign boundary = tick && (ptr == 2'd3);
    // The frame ending at this boundary counts toward the owner's hold.
    assign hold_met = (CMP_W'(hold) + CMP_W'(1)) >= CMP_W'(HOLD_FRAMES);

    // Free-running prescaler and digit pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
            ptr       <= 2'd0;
        end else begin
            prescaler <= prescaler + SCAN_DIV'(1);
            if (tick) begin
                ptr <= ptr + 2'd1;
            end
        end
    end

    // State register with grant, round-robin, hold and frame bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b0;
            last_owner <= 1'b1;
            hold       <= '0;
            frame      <= 16'h0000;
        end else begin
            state <= state_next;
            gnt_a <= (state_next == OWN_A);
            gnt_b <= (state_next == OWN_B);
            if (boundary) begin
                if (state_next != state) begin
                    hold <= '0;
                end else if (CMP_W'(hold) < CMP_W'(HOLD_FRAMES)) begin
                    hold <= hold + HOLD_W'(1);
                end
                case (state_next)
                    OWN_A: begin
                        frame      <= data_a;
                        last_owner <= 1'b0;
                    end
                    OWN_B: begin
                        frame      <= data_b;
                        last_owner <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Next-state logic; ownership only moves at frame boundaries.
    always_comb begin
        state_next = state;
        if (boundary) begin
            case (state)
                IDLE: begin
                    if (req_a && req_b) begin
                        state_next = last_owner ? OWN_A : OWN_B;
                    end else if (req_a) begin
                        state_next = OWN_A;
                    end else if (req_b) begin
                        state_next = OWN_B;
                    end
                end
                OWN_A: begin
                    if (!req_a) begin
                        state_next = req_b ? OWN_B : IDLE;
                    end else if (req_b && hold_met) begin
                        state_next = OWN_B;
                    end
                end
                OWN_B: begin
                    if (!req_b) begin
                        state_next = req_a ? OWN_A : IDLE;
                    end else if (req_a && hold_met) begin
                        state_next = OWN_A;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Digit drive and segment decode from registered state only.
    always_comb begin
        DIGIT   = 4'b1111;
        DISPLAY = 7'b1111111;
        nibble  = 4'h0;
        if (state != IDLE) begin
            case (ptr)
                2'd0: begin
                    DIGIT  = 4'b1110;
                    nibble = frame[3:0];
                end
                2'd1: begin
                    DIGIT  = 4'b1101;
                    nibble = frame[7:4];
                end
                2'd2: begin
                    DIGIT  = 4'b1011;
                    nibble = frame[11:8];
                end
                default: begin
                    DIGIT  = 4'b0111;
                    nibble = frame[15:12];
                end
            endcase
            DISPLAY = seg_decode(nibble);
        end
    end

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Bench for seg_scan_arbiter with SCAN_DIV=2 (tick every 4 clk, frame 16 clk)
// and HOLD_FRAMES=2. A cycle-count model of the arbitration rules predicts
// grants and digit/segment outputs after every clock edge.
// Honours SEG_SCAN_HEX_EN the same way the design does.
module tb_seg_scan_arbiter;

    localparam int unsigned HOLD = 2;
    localparam int unsigned N_CYCLES = 3000;

    logic        clk;
    logic        reset;
    logic        req_a;
    logic [15:0] data_a;
    logic        req_b;
    logic [15:0] data_b;
    logic        gnt_a;
    logic        gnt_b;
    logic [3:0]  digit;
    logic [0:6]  display;

    int errors;
    int checks;

    // Model state: owner 0 = none, 1 = A, 2 = B.
    int          m_cnt;
    int          m_owner;
    int          m_last;
    int          m_owned;
    logic [15:0] m_frame;

    logic [15:0] patterns [6];

    seg_scan_arbiter #(
        .SCAN_DIV   (2),
        .HOLD_FRAMES(HOLD)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req_a  (req_a),
        .data_a (data_a),
        .req_b  (req_b),
        .data_b (data_b),
        .gnt_a  (gnt_a),
        .gnt_b  (gnt_b),
        .DIGIT  (digit),
        .DISPLAY(display)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_ref(input logic [3:0] n);
        logic [6:0] t [16];
        t[0] = 7'b0000001; t[1] = 7'b1001111; t[2] = 7'b0010010; t[3] = 7'b0000110;
        t[4] = 7'b1001100; t[5] = 7'b0100100; t[6] = 7'b0100000; t[7] = 7'b0001111;
        t[8] = 7'b0000000; t[9] = 7'b0000100;
`ifdef SEG_SCAN_HEX_EN
        t[10] = 7'b0001000; t[11] = 7'b1100000; t[12] = 7'b0110001;
        t[13] = 7'b1000010; t[14] = 7'b0110000; t[15] = 7'b0111000;
`else
        for (int k = 10; k < 16; k++) t[k] = 7'b1111110;
`endif
        return t[n];
    endfunction

    task automatic model_reset();
        m_cnt   = 0;
        m_owner = 0;
        m_last  = 2;
        m_owned = 0;
        m_frame = 16'h0000;
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_step();
        int nxt;
        int other;
        logic rx;
        logic ry;
        if ((m_cnt % 16) == 15) begin
            nxt = m_owner;
            if (m_owner == 0) begin
                if (req_a && req_b) nxt = (m_last == 1) ? 2 : 1;
                else if (req_a)     nxt = 1;
                else if (req_b)     nxt = 2;
            end else begin
                other = (m_owner == 1) ? 2 : 1;
                rx = (m_owner == 1) ? req_a : req_b;
                ry = (m_owner == 1) ? req_b : req_a;
                if (!rx)                           nxt = ry ? other : 0;
                else if (ry && (m_owned + 1 >= HOLD)) nxt = other;
            end
            if (nxt != m_owner) m_owned = 0;
            else if (m_owned < HOLD) m_owned++;
            if (nxt != 0) begin
                m_last  = nxt;
                m_frame = (nxt == 1) ? data_a : data_b;
            end
            m_owner = nxt;
        end
        m_cnt++;
    endtask

    task automatic check_outputs();
        int   p;
        logic [3:0] e_dig;
        logic [6:0] e_seg;
        logic [15:0] sh;
        p = (m_cnt / 4) % 4;
        if (m_owner == 0) begin
            e_dig = 4'b1111;
            e_seg = 7'b1111111;
        end else begin
            e_dig = ~(4'(1) << p);
            sh    = m_frame >> (4 * p);
            e_seg = seg_ref(sh[3:0]);
        end
        check_eq("gnt_a", 32'(gnt_a), 32'(m_owner == 1));
        check_eq("gnt_b", 32'(gnt_b), 32'(m_owner == 2));
        check_eq("gnt_both", 32'(gnt_a & gnt_b), 32'd0);
        check_eq("digit", 32'(digit), 32'(e_dig));
        check_eq("display", 32'({display[0], display[1], display[2], display[3],
                                  display[4], display[5], display[6]}), 32'(e_seg));
    endtask

    // Phased stimulus: lone A, contention, hex data, then random traffic.
    task automatic drive(input int i);
        if (i < 60) begin
            req_a = 1'b1; data_a = 16'h1234; req_b = 1'b0;
        end else if (i < 240) begin
            req_a = 1'b1; req_b = 1'b1;
            data_a = (i < 150) ? 16'h1234 : 16'h5678;
            data_b = 16'h9087;
        end else if (i < 320) begin
            req_a = 1'b1; req_b = 1'b0; data_a = 16'h00AF;
        end else begin
            if ($urandom_range(0, 39) == 0) req_a = ~req_a;
            if ($urandom_range(0, 39) == 0) req_b = ~req_b;
            if ($urandom_range(0, 9) == 0)
                data_a = ($urandom_range(0, 1) == 0) ? patterns[$urandom_range(0, 5)] : 16'($urandom);
            if ($urandom_range(0, 9) == 0)
                data_b = ($urandom_range(0, 1) == 0) ? patterns[$urandom_range(0, 5)] : 16'($urandom);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        patterns[0] = 16'h1234; patterns[1] = 16'h5678; patterns[2] = 16'h00AF;
        patterns[3] = 16'h9999; patterns[4] = 16'hFEDC; patterns[5] = 16'h0000;
        req_a  = 1'b0;
        req_b  = 1'b0;
        data_a = 16'h0000;
        data_b = 16'h0000;
        reset  = 1'b0;
        model_reset();
        #1;
        check_outputs();
        repeat (3) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < int'(N_CYCLES); i++) begin
            @(posedge clk);
            model_step();
            #1;
            check_outputs();
            if (i == 1700 || i == 2333) begin
                // Asynchronous reset partway through a frame.
                req_a = 1'b1;
                req_b = 1'b1;
                #2;
                reset = 1'b0;
                #1;
                model_reset();
                check_eq("rst_gnt_a", 32'(gnt_a), 32'd0);
                check_eq("rst_gnt_b", 32'(gnt_b), 32'd0);
                check_eq("rst_digit", 32'(digit), 32'hF);
                check_eq("rst_display", 32'(display), 32'h7F);
                @(negedge clk);
                reset = 1'b1;
            end else begin
                drive(i);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
